leaf_out_packetizer: RTL and testbench

LEAF_OUT_PACKETIZER -- requirements
Module: leaf_out_packetizer

---
 rtl/leaf_out_packetizer.sv | 182 ++++++++++++++++++
 tb/tb_leaf_out_packetizer.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/leaf_out_packetizer.sv
// Packs user words into BFT packets {valid, leaf, port, addr, payload} behind a skid FIFO,
// gated by receiver credits. Define LEAF_OUT_PACKETIZER_STATS_EN to add grant/stall counters.
module leaf_out_packetizer #(
    parameter int PACKET_BITS           = 49,
    parameter int PAYLOAD_BITS          = 32,
    parameter int NUM_LEAF_BITS         = 5,
    parameter int NUM_PORT_BITS         = 4,
    parameter int NUM_ADDR_BITS         = 7,
    parameter int FREESPACE_UPDATE_SIZE = 64,
    parameter int FIFO_DEPTH            = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [PAYLOAD_BITS-1:0]  din_leaf_user2interface,
    input  logic                     vld_user2interface,
    output logic                     ack_interface2user,
    input  logic [NUM_LEAF_BITS-1:0] dest_leaf,
    input  logic [NUM_PORT_BITS-1:0] dest_port,
    input  logic                     credit_upd,
    input  logic                     resend,
    output logic [PACKET_BITS-1:0]   dout_pkt,
    input  logic                     pkt_grant,
`ifdef LEAF_OUT_PACKETIZER_STATS_EN
    output logic [31:0]              stat_pkts_sent,
    output logic [31:0]              stat_stall_cycles,
`endif
    output logic [1:0]               o_dbg_state,
    output logic [NUM_ADDR_BITS:0]   o_dbg_credit,
    output logic [NUM_ADDR_BITS-1:0] o_dbg_addr
);

    localparam int PTR_BITS   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_BITS   = PTR_BITS + 1;
    localparam int CRED_BITS  = NUM_ADDR_BITS + 1;
    localparam int CREDIT_MAX = 2 ** NUM_ADDR_BITS;

    // Debug state encoding: IDLE=0, HOLD=1, NOCRED=2.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_NOCRED = 2'd2
    } state_t;

    state_t                    r_state;
    logic [PACKET_BITS-1:0]    r_pkt;
    logic [NUM_ADDR_BITS-1:0]  r_addr;
    logic [CRED_BITS-1:0]      r_credit;
    logic [PAYLOAD_BITS-1:0]   r_mem [FIFO_DEPTH];
    logic [PTR_BITS-1:0]       r_wr_ptr;
    logic [PTR_BITS-1:0]       r_rd_ptr;
    logic [CNT_BITS-1:0]       r_count;
    logic                      r_ack;

    logic                      w_push;
    logic                      w_grant;
    logic                      w_upd;
    logic [PTR_BITS-1:0]       w_rd_ptr_inc;
    logic [PAYLOAD_BITS-1:0]   w_head;
    logic [PAYLOAD_BITS-1:0]   w_next_word;
    logic [CNT_BITS-1:0]       w_count_nxt;
    logic [31:0]               w_cred_sum;
    logic [CRED_BITS-1:0]      w_credit_nxt;

    // Handshakes: a user word transfers on a rising edge where vld_user2interface and
    // ack_interface2user are both high; a packet transfers where dout_pkt[MSB] and pkt_grant are both high.
    assign w_push       = vld_user2interface && r_ack;
    assign w_grant      = (r_state == ST_HOLD) && pkt_grant && !resend;
    assign w_upd        = credit_upd && !resend;
    assign w_rd_ptr_inc = r_rd_ptr + PTR_BITS'(1);
    assign w_head       = r_mem[r_rd_ptr];
    assign w_next_word  = r_mem[w_rd_ptr_inc];
    assign w_count_nxt  = r_count + CNT_BITS'(w_push) - CNT_BITS'(w_grant);

    // Grant and credit return in the same cycle both apply, then saturate.
    always_comb begin
        w_cred_sum   = 32'(r_credit);
        w_credit_nxt = r_credit;
        if (w_grant) w_cred_sum = w_cred_sum - 32'd1;
        if (w_upd) w_cred_sum = w_cred_sum + 32'(FREESPACE_UPDATE_SIZE);
        if (w_cred_sum > 32'(CREDIT_MAX)) w_credit_nxt = CRED_BITS'(CREDIT_MAX);
        else w_credit_nxt = w_cred_sum[CRED_BITS-1:0];
    end

    function automatic logic [PACKET_BITS-1:0] build_pkt(
        input logic [NUM_LEAF_BITS-1:0] leaf,
        input logic [NUM_PORT_BITS-1:0] port,
        input logic [NUM_ADDR_BITS-1:0] addr,
        input logic [PAYLOAD_BITS-1:0]  data
    );
        return PACKET_BITS'({1'b1, leaf, port, addr, data});
    endfunction

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= din_leaf_user2interface;
    end

    // The head entry stays in the FIFO while its packet is held, so it counts toward occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ack    <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_BITS'(1);
            if (w_grant) r_rd_ptr <= w_rd_ptr_inc;
            r_count <= w_count_nxt;
            r_ack   <= (w_count_nxt < CNT_BITS'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_pkt    <= '0;
            r_addr   <= '0;
            r_credit <= CRED_BITS'(CREDIT_MAX);
        end else if (!resend) begin
            r_credit <= w_credit_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (r_count != '0) begin
                        if (r_credit != '0) begin
                            r_state <= ST_HOLD;
                            r_pkt   <= build_pkt(dest_leaf, dest_port, r_addr, w_head);
                        end else begin
                            r_state <= ST_NOCRED;
                        end
                    end
                end
                ST_NOCRED: begin
                    if (r_credit != '0) begin
                        r_state <= ST_HOLD;
                        r_pkt   <= build_pkt(dest_leaf, dest_port, r_addr, w_head);
                    end
                end
                ST_HOLD: begin
                    if (pkt_grant) begin
                        r_addr <= r_addr + NUM_ADDR_BITS'(1);
                        // Chain straight into the next word when one is queued behind the head.
                        if ((r_count > CNT_BITS'(1)) && (w_credit_nxt != '0)) begin
                            r_pkt <= build_pkt(dest_leaf, dest_port,
                                               r_addr + NUM_ADDR_BITS'(1), w_next_word);
                        end else begin
                            r_pkt   <= '0;
                            r_state <= (r_count > CNT_BITS'(1)) ? ST_NOCRED : ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_pkt   <= '0;
                end
            endcase
        end
    end

`ifdef LEAF_OUT_PACKETIZER_STATS_EN
    logic [31:0] r_pkts_sent;
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pkts_sent    <= '0;
            r_stall_cycles <= '0;
        end else begin
            if (w_grant) r_pkts_sent <= r_pkts_sent + 32'd1;
            if (r_state == ST_NOCRED) r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stat_pkts_sent    = r_pkts_sent;
    assign stat_stall_cycles = r_stall_cycles;
`endif

    assign ack_interface2user = r_ack;
    assign dout_pkt           = resend ? '0 : r_pkt;
    assign o_dbg_state        = r_state;
    assign o_dbg_credit       = r_credit;
    assign o_dbg_addr         = r_addr;

endmodule

// File: tb/tb_leaf_out_packetizer.sv
// Bench for leaf_out_packetizer: directed scenarios plus randomized traffic scored against
// a transaction-level model (packet queue, credit count, occupancy).
module tb_leaf_out_packetizer;

    localparam int PB      = 49;
    localparam int DW      = 32;
    localparam int AW      = 7;
    localparam int DEPTH   = 4;
    localparam int CMAX    = 128;
    localparam int CUPD    = 64;

    logic          clk;
    logic          reset_n;
    logic [DW-1:0] din;
    logic          vld;
    logic          ack;
    logic [4:0]    dest_leaf;
    logic [3:0]    dest_port;
    logic          credit_upd;
    logic          resend;
    logic [PB-1:0] dout_pkt;
    logic          pkt_grant;
    logic [1:0]    dbg_state;
    logic [AW:0]   dbg_credit;
    logic [AW-1:0] dbg_addr;
`ifdef LEAF_OUT_PACKETIZER_STATS_EN
    logic [31:0]   stat_pkts_sent;
    logic [31:0]   stat_stall_cycles;
`endif

    leaf_out_packetizer dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .din_leaf_user2interface (din),
        .vld_user2interface      (vld),
        .ack_interface2user      (ack),
        .dest_leaf               (dest_leaf),
        .dest_port               (dest_port),
        .credit_upd              (credit_upd),
        .resend                  (resend),
        .dout_pkt                (dout_pkt),
        .pkt_grant               (pkt_grant),
`ifdef LEAF_OUT_PACKETIZER_STATS_EN
        .stat_pkts_sent          (stat_pkts_sent),
        .stat_stall_cycles       (stat_stall_cycles),
`endif
        .o_dbg_state             (dbg_state),
        .o_dbg_credit            (dbg_credit),
        .o_dbg_addr              (dbg_addr)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard / reference model ----------------
    logic [PB-1:0] exp_q[$];
    int            m_cred = CMAX;
    int            m_occ = 0;
    int            m_sent = 0;
    int            m_accepted = 0;
    bit            m_rdy = 0;
    logic [PB-1:0] held;
    bit            held_v = 0;

    always @(negedge clk) begin : monitor
        logic [PB-1:0] exp_pkt;
        bit push;
        bit g;
        bit u;
        if (!reset_n) begin
            check("rst_dout", 64'(dout_pkt), 64'd0);
            check("rst_ack", 64'(ack), 64'd0);
            m_cred = CMAX; m_occ = 0; m_sent = 0; m_accepted = 0;
            m_rdy = 0; held_v = 0;
            exp_q.delete();
        end else begin
            check("credit", 64'(dbg_credit), 64'(m_cred));
            check("ack", 64'(ack), 64'(m_rdy && (m_occ < DEPTH)));
            if (resend) check("resend_dout", 64'(dout_pkt), 64'd0);
            else if (held_v) check("hold_stable", 64'(dout_pkt), 64'(held));
            if (dout_pkt[PB-1]) check("valid_has_credit", 64'(m_cred > 0), 64'd1);
            push = vld && ack;
            g    = pkt_grant && dout_pkt[PB-1];
            u    = credit_upd && !resend;
            if (push) begin
                exp_q.push_back({1'b1, dest_leaf, dest_port, 7'd0, din});
                m_occ++;
                m_accepted++;
            end
            if (g) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pkt", 64'(dout_pkt), 64'd0);
                end else begin
                    exp_pkt = exp_q.pop_front();
                    exp_pkt[DW +: AW] = 7'(m_sent % CMAX);
                    check("pkt", 64'(dout_pkt), 64'(exp_pkt));
                end
                m_sent++;
                m_occ--;
                held_v = 0;
            end else if (!resend && dout_pkt[PB-1]) begin
                held   = dout_pkt;
                held_v = 1;
            end
            m_cred = m_cred - int'(g) + (u ? CUPD : 0);
            if (m_cred > CMAX) m_cred = CMAX;
            m_rdy = 1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        vld = 0; pkt_grant = 0; credit_upd = 0; resend = 0;
        reset_n = 0;
        tick(); tick();
        reset_n = 1;
    endtask

    task automatic send_word(input logic [DW-1:0] d);
        int n = 0;
        vld = 1;
        din = d;
        while (!ack && n < 2000) begin
            tick();
            n++;
        end
        if (!ack) begin
            check("send_timeout", 64'(ack), 64'd1);
            vld = 0;
            return;
        end
        tick();
        vld = 0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!dout_pkt[PB-1] && n < 500) begin
            tick();
            n++;
        end
        check(tag, 64'(dout_pkt[PB-1]), 64'd1);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        pkt_grant = 1;
        resend = 0;
        vld = 0;
        while (n < 3000 && !(exp_q.size() == 0 && dbg_state == 2'd0)) begin
            credit_upd = (n % 16 == 15);
            tick();
            n++;
        end
        credit_upd = 0;
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    logic [PB-1:0] exp_const;
    logic [PB-1:0] saved;
    int            sent;
    int            nwords;
    int            cyc;
    bit            hs;

    initial begin
        reset_n = 0; vld = 0; din = '0; dest_leaf = '0; dest_port = '0;
        credit_upd = 0; resend = 0; pkt_grant = 0;
        tick(); tick(); tick();
        reset_n = 1;

        // reset state
        check("rst_state", 64'(dbg_state), 64'd0);
        check("rst_credit", 64'(dbg_credit), 64'd128);
        check("rst_addr", 64'(dbg_addr), 64'd0);
        check("rst_ack_low", 64'(ack), 64'd0);
        tick();
        check("ack_rises", 64'(ack), 64'd1);

        // single word, two-cycle latency
        pkt_grant = 1; dest_leaf = 5'd3; dest_port = 4'd2;
        vld = 1; din = 32'hDEADBEEF;
        tick();
        vld = 0;
        check("lat_one_cycle", 64'(dout_pkt), 64'd0);
        tick();
        exp_const = {1'b1, 5'd3, 4'd2, 7'd0, 32'hDEADBEEF};
        check("lat_two_cycles", 64'(dout_pkt), 64'(exp_const));
        tick();
        check("single_credit", 64'(dbg_credit), 64'd127);
        check("single_addr", 64'(dbg_addr), 64'd1);
        check("single_idle", 64'(dbg_state), 64'd0);
`ifdef LEAF_OUT_PACKETIZER_STATS_EN
        check("stat_sent_1", 64'(stat_pkts_sent), 64'd1);
        check("stat_stall_0", 64'(stat_stall_cycles), 64'd0);
`endif

        // credit exhaustion and replenish with address wrap
        apply_reset();
        pkt_grant = 1;
        dest_leaf = 5'($urandom); dest_port = 4'($urandom);
        for (int i = 0; i < 130; i++) send_word($urandom);
        for (int i = 0; i < 10; i++) tick();
        check("exhaust_sent", 64'(m_sent), 64'd128);
        check("exhaust_state", 64'(dbg_state), 64'd2);
        check("exhaust_credit", 64'(dbg_credit), 64'd0);
        credit_upd = 1;
        tick();
        credit_upd = 0;
        for (int i = 0; i < 62; i++) send_word($urandom);
        for (int i = 0; i < 20; i++) tick();
        check("replenish_sent", 64'(m_sent), 64'd192);
        check("replenish_credit", 64'(dbg_credit), 64'd0);
        check("replenish_idle", 64'(dbg_state), 64'd0);

        // back-pressure: FIFO full after four words
        apply_reset();
        pkt_grant = 0;
        for (int i = 0; i < 4; i++) send_word(32'h1000 + 32'(i));
        vld = 1; din = 32'h1004;
        for (int i = 0; i < 5; i++) tick();
        check("full_ack", 64'(ack), 64'd0);
        check("full_accepted", 64'(m_accepted), 64'd4);
        check("full_valid", 64'(dout_pkt[PB-1]), 64'd1);
        pkt_grant = 1;
        send_word(32'h1004);
        drain("full_drain");
        check("full_sent", 64'(m_sent), 64'd5);

        // grant and credit return together saturate
        apply_reset();
        pkt_grant = 0;
        send_word(32'hA5A5_0001);
        send_word(32'hA5A5_0002);
        wait_valid("sat_valid");
        pkt_grant = 1;
        tick();
        pkt_grant = 0;
        check("sat_pre_credit", 64'(dbg_credit), 64'd127);
        pkt_grant = 1; credit_upd = 1;
        tick();
        pkt_grant = 0; credit_upd = 0;
        check("sat_credit", 64'(dbg_credit), 64'd128);

        // resend freeze during HOLD
        apply_reset();
        pkt_grant = 0;
        send_word(32'h5EED_0001);
        wait_valid("resend_valid");
        saved = dout_pkt;
        resend = 1; pkt_grant = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("resend_zero", 64'(dout_pkt), 64'd0);
            check("resend_credit", 64'(dbg_credit), 64'd128);
            check("resend_addr", 64'(dbg_addr), 64'd0);
        end
        resend = 0; pkt_grant = 0;
        #1;
        check("resend_reappear", 64'(dout_pkt), 64'(saved));
        tick();
        pkt_grant = 1;
        tick();
        pkt_grant = 0;
        check("resend_after_credit", 64'(dbg_credit), 64'd127);

        // reset in the middle of HOLD
        apply_reset();
        pkt_grant = 0;
        send_word(32'hC0DE_0001);
        send_word(32'hC0DE_0002);
        wait_valid("midrst_valid");
        pkt_grant = 1;
        tick();
        pkt_grant = 0;
        #2;
        reset_n = 0;
        #1;
        check("midrst_dout", 64'(dout_pkt), 64'd0);
        check("midrst_ack", 64'(ack), 64'd0);
        tick(); tick();
        reset_n = 1;
        check("midrst_credit", 64'(dbg_credit), 64'd128);
        check("midrst_addr", 64'(dbg_addr), 64'd0);
        check("midrst_state", 64'(dbg_state), 64'd0);
`ifdef LEAF_OUT_PACKETIZER_STATS_EN
        check("midrst_stat_sent", 64'(stat_pkts_sent), 64'd0);
        check("midrst_stat_stall", 64'(stat_stall_cycles), 64'd0);
`endif
        tick(); tick();
        check("midrst_no_output", 64'(dout_pkt), 64'd0);

        // randomized traffic
        for (int phase = 0; phase < 6; phase++) begin
            dest_leaf = 5'($urandom);
            dest_port = 4'($urandom);
            nwords = $urandom_range(5, 40);
            sent = 0;
            cyc = 0;
            vld = 0;
            while (sent < nwords && cyc < 4000) begin
                if (!vld && $urandom_range(0, 3) != 0) begin
                    vld = 1;
                    din = $urandom;
                end
                pkt_grant  = ($urandom_range(0, 9) < 7);
                credit_upd = ($urandom_range(0, 15) == 0);
                resend     = ($urandom_range(0, 19) == 0);
                hs = vld && ack;
                tick();
                cyc++;
                if (hs) begin
                    sent++;
                    vld = 0;
                end
            end
            check("rand_sent", 64'(sent), 64'(nwords));
            credit_upd = 0;
            drain("rand_drain");
        end

        tick(); tick();
        check("final_queue", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
